// File: rtl/block_memory_retrieval.sv
// Read-side retrieval stage: looks up an SSID in the hits-new, hits-count and hit-info
// memories and streams the stored hit words out oldest first under valid/ready flow control.
module block_memory_retrieval #(
   parameter int SSIDBITS         = 12,
   parameter int COLINDEXBITS_HNM = 5,
   parameter int ROWINDEXBITS_HNM = 7,
   parameter int NCOLS_HCM        = 16,
   parameter int ROWINDEXBITS_HIM = 9,
   parameter int HITINFOBITS      = 8,
   parameter int MAXHITNBITS      = 4,
   parameter int MAXHITS          = 8,
   parameter int READLATENCY      = 1
) (
   input  logic                              clock,
   input  logic                              resetN,
   input  logic                              readMode,
   input  logic                              queryValid,
   output logic                              queryReady,
   input  logic [SSIDBITS-1:0]               querySSID,
   output logic [ROWINDEXBITS_HNM-1:0]       addrHNM,
   input  logic [(2**COLINDEXBITS_HNM)-1:0]  dataHNM,
   output logic [SSIDBITS-1:0]               addrHCM,
   input  logic [NCOLS_HCM-1:0]              dataHCM,
   output logic [ROWINDEXBITS_HIM-1:0]       addrHIM,
   input  logic [MAXHITS*HITINFOBITS-1:0]    dataHIM,
   output logic                              hitValid,
   input  logic                              hitReady,
   output logic [HITINFOBITS-1:0]            hitInfo,
   output logic                              hitLast,
   output logic                              queryDone,
   output logic [MAXHITNBITS-1:0]            hitCount,
   output logic                              countError,
   output logic                              queryAbort
);

   localparam int                     IDXBITS = $clog2(MAXHITS);
   localparam logic [1:0]             LAT     = 2'(READLATENCY);
   localparam logic [MAXHITNBITS-1:0] MAXN    = MAXHITNBITS'(MAXHITS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_HNM,
      S_WAIT_HCM,
      S_WAIT_HIM,
      S_EMIT,
      S_DONE
   } state_t;

   state_t                          r_state;
   logic [1:0]                      r_wait;
   logic [COLINDEXBITS_HNM-1:0]     r_col;
   logic                            r_miss;
   logic [MAXHITNBITS-1:0]          r_count;
   logic                            r_clamp;
   logic [MAXHITS*HITINFOBITS-1:0]  r_row;
   logic [IDXBITS-1:0]              r_idx;
   logic                            r_ready;

   logic                            w_accept;
   logic                            w_waitDone;
   logic                            w_hnmBit;
   logic [MAXHITNBITS-1:0]          w_hcmCount;
   logic [ROWINDEXBITS_HIM-1:0]     w_hcmAddr;
   logic                            w_xfer;
   logic                            w_unusedHcm;
   logic [HITINFOBITS-1:0]          w_slots [MAXHITS];

   assign queryReady  = r_ready & readMode;
   assign w_accept    = queryValid & queryReady;
   assign w_waitDone  = (r_wait == LAT);
   assign w_hnmBit    = dataHNM[r_col];
   assign w_hcmCount  = dataHCM[MAXHITNBITS-1:0];
   assign w_hcmAddr   = dataHCM[NCOLS_HCM-1 -: ROWINDEXBITS_HIM];
   assign w_xfer      = hitValid & hitReady;
   assign w_unusedHcm = ^dataHCM;

   // Slot 0 holds the newest hit, so emission walks the slot index downward.
   for (genvar g = 0; g < MAXHITS; g++) begin : gSlot
      assign w_slots[g] = r_row[g*HITINFOBITS +: HITINFOBITS];
   end

   assign hitInfo = hitValid ? w_slots[r_idx] : '0;
   assign hitLast = hitValid & (r_idx == '0);

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_state    <= S_IDLE;
         r_wait     <= '0;
         r_col      <= '0;
         r_miss     <= 1'b0;
         r_count    <= '0;
         r_clamp    <= 1'b0;
         r_row      <= '0;
         r_idx      <= '0;
         r_ready    <= 1'b0;
         addrHNM    <= '0;
         addrHCM    <= '0;
         addrHIM    <= '0;
         hitValid   <= 1'b0;
         queryDone  <= 1'b0;
         hitCount   <= '0;
         countError <= 1'b0;
         queryAbort <= 1'b0;
      end else begin
         queryDone  <= 1'b0;
         countError <= 1'b0;
         queryAbort <= 1'b0;
         if (r_state != S_IDLE && !readMode) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            hitValid   <= 1'b0;
            queryAbort <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_ready <= 1'b1;
                  if (w_accept) begin
                     r_col   <= querySSID[COLINDEXBITS_HNM-1:0];
                     addrHNM <= querySSID[SSIDBITS-1:COLINDEXBITS_HNM];
                     addrHCM <= querySSID;
                     r_wait  <= '0;
                     r_miss  <= 1'b0;
                     r_clamp <= 1'b0;
                     r_ready <= 1'b0;
                     r_state <= S_WAIT_HNM;
                  end
               end
               // A miss still walks the HCM wait so every query ends on a fixed cadence.
               S_WAIT_HNM: begin
                  if (w_waitDone) begin
                     r_wait  <= '0;
                     r_miss  <= ~w_hnmBit;
                     r_state <= S_WAIT_HCM;
                  end else begin
                     r_wait <= r_wait + 1'b1;
                  end
               end
               S_WAIT_HCM: begin
                  if (w_waitDone) begin
                     r_wait <= '0;
                     if (r_miss || w_hcmCount == '0) begin
                        r_count   <= '0;
                        hitCount  <= '0;
                        queryDone <= 1'b1;
                        r_state   <= S_DONE;
                     end else begin
                        addrHIM <= w_hcmAddr;
                        r_state <= S_WAIT_HIM;
                        if (w_hcmCount > MAXN) begin
                           r_count <= MAXN;
                           r_clamp <= 1'b1;
                        end else begin
                           r_count <= w_hcmCount;
                        end
                     end
                  end else begin
                     r_wait <= r_wait + 1'b1;
                  end
               end
               S_WAIT_HIM: begin
                  if (w_waitDone) begin
                     r_wait   <= '0;
                     r_row    <= dataHIM;
                     r_idx    <= IDXBITS'(r_count - 1'b1);
                     hitValid <= 1'b1;
                     r_state  <= S_EMIT;
                  end else begin
                     r_wait <= r_wait + 1'b1;
                  end
               end
               S_EMIT: begin
                  if (w_xfer) begin
                     if (r_idx == '0) begin
                        hitValid   <= 1'b0;
                        queryDone  <= 1'b1;
                        hitCount   <= r_count;
                        countError <= r_clamp;
                        r_state    <= S_DONE;
                     end else begin
                        r_idx <= r_idx - 1'b1;
                     end
                  end
               end
               S_DONE: begin
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
